ysyx_22041461_mem_lsu: RTL

- MEM-stage load/store unit. Consumes the MEM pipeline register outputs (valid, MEM_ctrl, EXE result as address, store data) and issues requests to data memory over a valid/ready request channel with a separate response channel.
- Drives `mem_stall` low-true into `MEMreg_enable` so the MEM register holds while an access is outstanding.
- Returns sign/zero-extended load data and a misalignment flag to WB.

---
 rtl/ysyx_22041461_mem_lsu_pkg.sv | 59 +++++
 rtl/ysyx_22041461_mem_lsu_fmt.sv | 47 ++++
 rtl/ysyx_22041461_mem_lsu.sv | 137 +++++++++++++
 3 files changed

// File: rtl/ysyx_22041461_mem_lsu_pkg.sv
// rtl/ysyx_22041461_mem_lsu_pkg.sv - MEM_ctrl opcodes, LSU state encoding and opcode decode helpers
package ysyx_22041461_mem_lsu_pkg;

    localparam int LSU_DATA_W = 64;
    localparam int LSU_NBYTES = 8;

    localparam logic [3:0] MEM_NOP = 4'd0;
    localparam logic [3:0] MEM_LB  = 4'd1;
    localparam logic [3:0] MEM_LH  = 4'd2;
    localparam logic [3:0] MEM_LW  = 4'd3;
    localparam logic [3:0] MEM_LD  = 4'd4;
    localparam logic [3:0] MEM_LBU = 4'd5;
    localparam logic [3:0] MEM_LHU = 4'd6;
    localparam logic [3:0] MEM_LWU = 4'd7;
    localparam logic [3:0] MEM_SB  = 4'd8;
    localparam logic [3:0] MEM_SH  = 4'd9;
    localparam logic [3:0] MEM_SW  = 4'd10;
    localparam logic [3:0] MEM_SD  = 4'd11;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_e;

    // Codes 12..15 fall outside the range and behave as NOP.
    function automatic logic is_mem_op(input logic [3:0] op);
        return (op >= MEM_LB) && (op <= MEM_SD);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op >= MEM_SB) && (op <= MEM_SD);
    endfunction

    // log2 of the access size in bytes.
    function automatic logic [1:0] op_size(input logic [3:0] op);
        logic [1:0] sz;
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: sz = 2'd0;
            MEM_LH, MEM_LHU, MEM_SH: sz = 2'd1;
            MEM_LW, MEM_LWU, MEM_SW: sz = 2'd2;
            default:                 sz = 2'd3;
        endcase
        return sz;
    endfunction

    function automatic logic is_aligned(input logic [3:0] op, input logic [2:0] off);
        logic ok;
        case (op_size(op))
            2'd0:    ok = 1'b1;
            2'd1:    ok = (off[0] == 1'b0);
            2'd2:    ok = (off[1:0] == 2'b00);
            default: ok = (off == 3'b000);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ysyx_22041461_mem_lsu_fmt.sv
// rtl/ysyx_22041461_mem_lsu_fmt.sv - combinational store lane/mask generator and load extractor/extender
module ysyx_22041461_mem_lsu_fmt
    import ysyx_22041461_mem_lsu_pkg::*;
(
    input  logic [3:0]            i_op,
    input  logic [2:0]            i_off,
    input  logic [LSU_DATA_W-1:0] i_wdata,
    input  logic [LSU_DATA_W-1:0] i_rdata,
    output logic [LSU_DATA_W-1:0] o_st_wdata,
    output logic [LSU_NBYTES-1:0] o_st_wmask,
    output logic [LSU_DATA_W-1:0] o_ld_data
);

    logic [5:0]            w_shamt;
    logic [LSU_DATA_W-1:0] w_rshift;

    assign w_shamt    = {i_off, 3'b000};
    assign w_rshift   = i_rdata >> w_shamt;
    assign o_st_wdata = i_wdata << w_shamt;

    always_comb begin
        o_st_wmask = '0;
        case (i_op)
            MEM_SB:  o_st_wmask = 8'h01 << i_off;
            MEM_SH:  o_st_wmask = 8'h03 << i_off;
            MEM_SW:  o_st_wmask = 8'h0F << i_off;
            MEM_SD:  o_st_wmask = 8'hFF;
            default: o_st_wmask = '0;
        endcase
    end

    // Stores and NOPs yield zero so a store completion returns ld_data = 0.
    always_comb begin
        o_ld_data = '0;
        case (i_op)
            MEM_LB:  o_ld_data = {{56{w_rshift[7]}},  w_rshift[7:0]};
            MEM_LH:  o_ld_data = {{48{w_rshift[15]}}, w_rshift[15:0]};
            MEM_LW:  o_ld_data = {{32{w_rshift[31]}}, w_rshift[31:0]};
            MEM_LD:  o_ld_data = w_rshift;
            MEM_LBU: o_ld_data = {56'd0, w_rshift[7:0]};
            MEM_LHU: o_ld_data = {48'd0, w_rshift[15:0]};
            MEM_LWU: o_ld_data = {32'd0, w_rshift[31:0]};
            default: o_ld_data = '0;
        endcase
    end

endmodule

// File: rtl/ysyx_22041461_mem_lsu.sv
// rtl/ysyx_22041461_mem_lsu.sv - MEM-stage load/store unit: request/response sequencing and pipeline stall
module ysyx_22041461_mem_lsu
    import ysyx_22041461_mem_lsu_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    input  logic [3:0]            i_mem_ctrl,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic [LSU_DATA_W-1:0] i_wdata,
    output logic                  o_mem_stall,
    output logic                  o_dmem_req_valid,
    input  logic                  i_dmem_req_ready,
    output logic                  o_dmem_req_wen,
    output logic [ADDR_W-1:0]     o_dmem_req_addr,
    output logic [LSU_DATA_W-1:0] o_dmem_req_wdata,
    output logic [LSU_NBYTES-1:0] o_dmem_req_wmask,
    input  logic                  i_dmem_resp_valid,
    input  logic [LSU_DATA_W-1:0] i_dmem_resp_rdata,
    output logic [LSU_DATA_W-1:0] o_ld_data,
    output logic                  o_ld_valid,
    output logic                  o_misalign_exc
);

    lsu_state_e r_state;
    lsu_state_e w_next;

    logic [3:0]            r_op;
    logic [2:0]            r_off;
    logic                  r_misalign;
    logic                  r_req_wen;
    logic [ADDR_W-1:0]     r_req_addr;
    logic [LSU_DATA_W-1:0] r_req_wdata;
    logic [LSU_NBYTES-1:0] r_req_wmask;
    logic [LSU_DATA_W-1:0] r_ld_data;

    logic                  w_idle;
    logic                  w_start;
    logic                  w_aligned;
    logic [3:0]            w_fmt_op;
    logic [2:0]            w_fmt_off;
    logic [LSU_DATA_W-1:0] w_st_wdata;
    logic [LSU_NBYTES-1:0] w_st_wmask;
    logic [LSU_DATA_W-1:0] w_ld_ext;

    assign w_idle    = (r_state == LSU_IDLE);
    // Gated by reset so every output, including the stall, reads 0 while in reset.
    assign w_start   = i_rst_n & i_valid & is_mem_op(i_mem_ctrl) & w_idle;
    assign w_aligned = is_aligned(i_mem_ctrl, i_addr[2:0]);

    // One formatter serves both directions: live inputs while capturing, the held copy afterwards.
    assign w_fmt_op  = w_idle ? i_mem_ctrl  : r_op;
    assign w_fmt_off = w_idle ? i_addr[2:0] : r_off;

    ysyx_22041461_mem_lsu_fmt u_fmt (
        .i_op       (w_fmt_op),
        .i_off      (w_fmt_off),
        .i_wdata    (i_wdata),
        .i_rdata    (i_dmem_resp_rdata),
        .o_st_wdata (w_st_wdata),
        .o_st_wmask (w_st_wmask),
        .o_ld_data  (w_ld_ext)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= LSU_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            LSU_IDLE: begin
                if (w_start) begin
                    w_next = w_aligned ? LSU_REQ : LSU_DONE;
                end
            end
            LSU_REQ: begin
                if (i_dmem_req_ready) begin
                    w_next = LSU_WAIT;
                end
            end
            LSU_WAIT: begin
                if (i_dmem_resp_valid) begin
                    w_next = LSU_DONE;
                end
            end
            LSU_DONE: w_next = LSU_IDLE;
            default:  w_next = LSU_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op        <= MEM_NOP;
            r_off       <= '0;
            r_misalign  <= 1'b0;
            r_req_wen   <= 1'b0;
            r_req_addr  <= '0;
            r_req_wdata <= '0;
            r_req_wmask <= '0;
            r_ld_data   <= '0;
        end else begin
            if (w_start) begin
                r_op       <= i_mem_ctrl;
                r_off      <= i_addr[2:0];
                r_misalign <= ~w_aligned;
                r_ld_data  <= '0;
                if (w_aligned) begin
                    r_req_wen   <= is_store(i_mem_ctrl);
                    r_req_addr  <= {i_addr[ADDR_W-1:3], 3'b000};
                    r_req_wdata <= w_st_wdata;
                    r_req_wmask <= w_st_wmask;
                end
            end
            if ((r_state == LSU_WAIT) && i_dmem_resp_valid) begin
                r_ld_data <= w_ld_ext;
            end
        end
    end

    assign o_mem_stall      = w_start | (r_state == LSU_REQ) | (r_state == LSU_WAIT);
    assign o_dmem_req_valid = (r_state == LSU_REQ);
    assign o_dmem_req_wen   = r_req_wen;
    assign o_dmem_req_addr  = r_req_addr;
    assign o_dmem_req_wdata = r_req_wdata;
    assign o_dmem_req_wmask = r_req_wmask;
    assign o_ld_data        = r_ld_data;
    assign o_ld_valid       = (r_state == LSU_DONE);
    assign o_misalign_exc   = (r_state == LSU_DONE) & r_misalign;

endmodule
